i2c_wb_arbiter: RTL

- Round-robin Wishbone arbiter that shares the single 8-bit register port of the I2C controller block between NUM_M bus masters (e.g. CPU and DMA/sequencer).
- Sits between the masters and the I2C block's wb_* slave port.
- Holds the grant for a whole locked cycle (wb_cyc high).
- Routes ack, read data and the I2C interrupt back to the owning master.

---
 rtl/i2c_arb_pkg.sv | 19 +
 rtl/i2c_rr_pick.sv | 29 ++
 rtl/i2c_wb_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C Wishbone register-port arbiter.
package i2c_arb_pkg;

   localparam int ADDR_W          = 8;
   localparam int DATA_W          = 8;
   localparam int TMO_CNT_W       = 8;
   localparam int DEF_TIMEOUT_CYC = 255;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Successor of a master index, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr_i,
// searching upward and wrapping.
module i2c_rr_pick #(
   parameter int NUM_M = 2,
   parameter int IDX_W = 1
) (
   input  logic [NUM_M-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest offset down so the nearest requester wins last.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = NUM_M - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr_i) + k) % NUM_M);
         if (req_i[cand]) begin
            idx_o   = cand;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing the I2C controller's 8-bit register port
// between NUM_M masters. Define I2C_ARB_TIMEOUT_EN to build the stb watchdog.
module i2c_wb_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NUM_M       = 2,
   parameter int IDX_W       = 1,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [NUM_M*ADDR_W-1:0]   m_add_i,
   input  logic [NUM_M*DATA_W-1:0]   m_data_i,
   input  logic [NUM_M-1:0]          m_we_i,
   input  logic [NUM_M-1:0]          m_stb_i,
   input  logic [NUM_M-1:0]          m_cyc_i,
   output logic [DATA_W-1:0]         m_data_o,
   output logic [NUM_M-1:0]          m_ack_o,
   output logic [NUM_M-1:0]          m_err_o,
   output logic [NUM_M-1:0]          irq_o,
   output logic [ADDR_W-1:0]         s_add_o,
   output logic [DATA_W-1:0]         s_data_o,
   output logic                      s_we_o,
   output logic                      s_stb_o,
   output logic                      s_cyc_o,
   input  logic [DATA_W-1:0]         s_data_i,
   input  logic                      s_ack_i,
   input  logic                      irq_i
);

   if (NUM_M < 2 || NUM_M > 4 || IDX_W != $clog2(NUM_M)) begin : g_bad_num_m
      $error("i2c_wb_arbiter: NUM_M must be 2..4 and IDX_W must be clog2(NUM_M)");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << TMO_CNT_W) - 1) begin : g_bad_tmo
      $error("i2c_wb_arbiter: TIMEOUT_CYC must fit the watchdog counter");
   end

   logic [NUM_M-1:0][ADDR_W-1:0] add_a;
   logic [NUM_M-1:0][DATA_W-1:0] dat_a;

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] irq_owner_q, irq_owner_d;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic             grant;
   logic             tmo;

   assign add_a = m_add_i;
   assign dat_a = m_data_i;

   i2c_rr_pick #(
      .NUM_M (NUM_M),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (m_cyc_i),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .valid_o (pick_vld)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         irq_owner_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         irq_owner_q <= irq_owner_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      irq_owner_d = irq_owner_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               owner_d     = pick_idx;
               irq_owner_d = pick_idx;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!m_cyc_i[owner_q] || tmo) begin
               state_d  = ST_IDLE;
               rr_ptr_d = IDX_W'(rr_next(int'(owner_q), NUM_M));
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state_q resets asynchronously, so stb/cyc/we fall as soon as reset rises.
   assign grant    = (state_q == ST_GRANT);
   assign s_cyc_o  = grant & m_cyc_i[owner_q];
   assign s_stb_o  = grant & m_stb_i[owner_q];
   assign s_we_o   = grant & m_we_i[owner_q];
   assign s_add_o  = wb_rst_i ? '0 : add_a[owner_q];
   assign s_data_o = wb_rst_i ? '0 : dat_a[owner_q];
   assign m_data_o = s_data_i;

   always_comb begin
      m_ack_o = '0;
      if (grant && s_ack_i) m_ack_o[owner_q] = 1'b1;
   end

   always_comb begin
      irq_o = '0;
      irq_o[irq_owner_q] = irq_i;
   end

`ifdef I2C_ARB_TIMEOUT_EN
   logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Fires in the stall cycle that brings the count up to TIMEOUT_CYC.
   assign tmo = grant & s_stb_o & ~s_ack_i &
                (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (!grant || s_ack_i || state_d == ST_IDLE) tmo_cnt_d = '0;
      else if (s_stb_o)                           tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) tmo_cnt_q <= '0;
      else          tmo_cnt_q <= tmo_cnt_d;
   end

   always_comb begin
      m_err_o = '0;
      if (tmo) m_err_o[owner_q] = 1'b1;
   end
`else
   assign tmo     = 1'b0;
   assign m_err_o = '0;
`endif

endmodule
